preg_free_list: RTL and testbench
=================================

# preg_free_list

Physical-register free list that sits directly upstream of RENAME and supplies the `free_PRegs` it consumes each cycle. It is a circular FIFO of unmapped physical-register indices. It pops up to two entries per cycle for the rename slots and pushes up to two entries per cycle released by retire (the previous mappings of retiring destinations). Allocation is all-or-nothing per cycle, and a back-pressure flag tells RENAME when to stall.

## Interface
- `NUM_PREGS`, 64, total physical registers; `p_reg` width is `$clog2(NUM_PREGS)`.
- `NUM_AREGS`, 32, architectural registers; P0..P(NUM_AREGS-1) are mapped at reset.
- `WIDTH`, 2, rename/retire slots per cycle.
- `i_clk`  in  1  clock; all state updates on posedge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_alloc_req [0:WIDTH-1]`  in  1 each  rename slot k needs a destination preg this cycle.
- `o_free_PRegs [0:WIDTH-1]`  out  p_reg each  preg granted to slot k; valid only when `i_alloc_req[k]` and `o_alloc_ok` are both high.
- `o_alloc_ok`  out  1  enough free entries for all asserted requests.
- `i_release_en [0:WIDTH-1]`  in  1 each  retire slot k frees a preg.
- `i_release_preg [0:WIDTH-1]`  in  p_reg each  preg being freed.
- `o_free_count`  out  `$clog2(DEPTH+1)`  current number of entries.
- `o_err`  out  1  sticky error flag; see Configuration.

## Operation
- Storage: DEPTH = NUM_PREGS − NUM_AREGS entries. Pointers are head (pop) and tail (push), each `$clog2(DEPTH)` bits and wrapping modulo DEPTH, plus a count register.
- Reset: entry j = NUM_AREGS + j, head = 0, tail = 0, count = DEPTH, `o_err` = 0.
- Request packing: requesting slots are ordered by slot index. The first requester gets entry[head], the second gets entry[head+1]. A non-requesting slot drives entry[head] (don't-care).
- n_alloc = popcount(i_alloc_req). `o_alloc_ok` = (count ≥ n_alloc). When n_alloc = 0, `o_alloc_ok` = 1.
- On `o_alloc_ok` = 0, no entry is popped, head and count are unchanged, and RENAME must stall its whole group. Partial grants are never made.
- Release: enabled slots write at tail, tail+1 in slot order. n_rel = popcount(i_release_en).
- Count update: count ← count + n_rel − (o_alloc_ok ? n_alloc : 0).
- Simultaneous alloc and release: grant availability uses count before this cycle's releases. There is no same-cycle bypass, so a freed preg is allocatable the next cycle at the earliest.
- Overflow (count + n_rel > DEPTH) is impossible in correct operation. The push is dropped and the error is flagged when checks are enabled.
- Empty (count = 0): any request yields `o_alloc_ok` = 0, and releases still push.

## Timing
- `o_free_PRegs` and `o_alloc_ok` are combinational from registered state plus `i_alloc_req`, with zero-cycle latency to RENAME.
- Pointer, storage and count updates commit at posedge. `o_free_count` is registered.
- Release-to-reuse latency is 1 cycle.
- Reset mid-operation restores the full reset image asynchronously. All in-flight grants are discarded, and RENAME must flush alongside.
- Reset values: `o_free_count` = DEPTH, `o_alloc_ok` = 1, `o_free_PRegs[k]` = NUM_AREGS, `o_err` = 0.

## Configuration
- `FREE_LIST_CHECK_EN` defined:
  - a NUM_PREGS-bit "is free" bitmap tracks list membership.
  - `o_err` latches on any of: release of a preg already free (double-free), release of an index ≥ NUM_PREGS, overflow, or duplicate preg within one release group.
  - An erroneous release is not pushed.
- `FREE_LIST_CHECK_EN` undefined: there is no bitmap, `o_err` is tied 0, and all releases push unconditionally.

## Structure
- Package `Types` holds `p_reg`, plus the constants `NUM_PREGS`, `NUM_AREGS` and `FL_DEPTH`, shared with RENAME and retire.
- Sub-module `preg_alloc_tracker` implements the checking bitmap and is instantiated only under `FREE_LIST_CHECK_EN`. The FIFO itself stays in the top module.

## Test plan
- Reset, then request {1,1} → grants P32, P33, `o_alloc_ok` = 1; next cycle `o_free_count` = 30.
- Request {0,1} from reset → slot 1 gets P32, slot 0 don't-care; count = 31.
- Drain to count = 1, then request {1,1} → `o_alloc_ok` = 0, head and count unchanged. Request {1,0} instead → grants the last entry, count = 0.
- At count = 0, request {1,1} with release {P5, P7} the same cycle → `o_alloc_ok` = 0. Next cycle request {1,1} → grants P5, P7.
- Allocate 40 pregs while releasing steadily so the pointers wrap → grant order equals release order and the count never exceeds 32.
- With `FREE_LIST_CHECK_EN` defined, release P40 twice → `o_err` = 1 and stays set, and count increments only once. Then assert `i_rst_n` = 0 mid-run → `o_err` = 0 and count = 32 immediately.

Source files
------------

// File: rtl/Types.sv
// Shared rename types: physical-register index type and free-list sizing,
// used by RENAME, retire and the physical-register free list.
package Types;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int FL_WIDTH  = 2;

    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int PTR_W  = $clog2(FL_DEPTH);
    localparam int CNT_W  = $clog2(FL_DEPTH + 1);

    typedef logic [PREG_W-1:0] p_reg;
    typedef logic [PTR_W-1:0]  fl_ptr;
    typedef logic [CNT_W-1:0]  fl_cnt;

    // Circular-pointer advance; off never exceeds FL_WIDTH, so one subtract wraps.
    function automatic fl_ptr ptr_add(input fl_ptr p, input int off);
        int sum;
        sum = int'(p) + off;
        if (sum >= FL_DEPTH) sum = sum - FL_DEPTH;
        return fl_ptr'(sum);
    endfunction

endpackage

// File: rtl/preg_alloc_tracker.sv
// "Is free" bitmap guarding the free list: rejects double-frees, out-of-range
// indices, in-group duplicates and overflowing pushes, and latches a sticky error.
module preg_alloc_tracker
    import Types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pop_en       [FL_WIDTH],
    input  logic [PREG_W-1:0] pop_preg     [FL_WIDTH],
    input  logic              release_en   [FL_WIDTH],
    input  logic [PREG_W-1:0] release_preg [FL_WIDTH],
    input  logic [CNT_W-1:0]  count,
    output logic              push_en      [FL_WIDTH],
    output logic              err
);

    localparam logic [NUM_PREGS-1:0] FREE_AT_RESET = {{FL_DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};

    logic [NUM_PREGS-1:0] is_free;
    logic                 reject;

    // Membership is judged against the bitmap before this cycle's pops and pushes.
    always_comb begin
        int  pushed;
        logic bad;
        pushed = 0;
        reject = 1'b0;
        for (int k = 0; k < FL_WIDTH; k++) begin
            bad        = 1'b0;
            push_en[k] = 1'b0;
            if (release_en[k]) begin
                bad = ({1'b0, release_preg[k]} >= (PREG_W+1)'(NUM_PREGS));
                if (!bad) bad = is_free[release_preg[k]];
                for (int j = 0; j < k; j++)
                    if (release_en[j] && release_preg[j] == release_preg[k]) bad = 1'b1;
                if (int'(count) + pushed >= FL_DEPTH) bad = 1'b1;
                push_en[k] = !bad;
                if (!bad) pushed = pushed + 1;
                reject = reject | bad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_free <= FREE_AT_RESET;
            err     <= 1'b0;
        end else begin
            for (int k = 0; k < FL_WIDTH; k++)
                if (pop_en[k]) is_free[pop_preg[k]] <= 1'b0;
            for (int k = 0; k < FL_WIDTH; k++)
                if (push_en[k]) is_free[release_preg[k]] <= 1'b1;
            if (reject) err <= 1'b1;
        end
    end

endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO feeding RENAME, refilled by retire.
// Define FREE_LIST_CHECK_EN to add release checking and the sticky o_err flag.
module preg_free_list
    import Types::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_alloc_req    [0:FL_WIDTH-1],
    output logic [PREG_W-1:0] o_free_PRegs   [0:FL_WIDTH-1],
    output logic              o_alloc_ok,
    input  logic              i_release_en   [0:FL_WIDTH-1],
    input  logic [PREG_W-1:0] i_release_preg [0:FL_WIDTH-1],
    output logic [CNT_W-1:0]  o_free_count,
    output logic              o_err
);

    p_reg  entries  [FL_DEPTH];
    fl_ptr head;
    fl_ptr tail;
    fl_cnt count;

    fl_cnt n_alloc;
    fl_cnt n_push;
    fl_ptr push_ptr [FL_WIDTH];
    logic  pop_en   [FL_WIDTH];
    logic  push_en  [FL_WIDTH];

    // Requesters are packed in slot order from head; idle slots show entry[head].
    // NOTE: n_alloc is a running sum inside one combinational pass, so it must use
    // blocking updates; the registers below use non-blocking.
    always_comb begin
        n_alloc = '0;
        for (int k = 0; k < FL_WIDTH; k++) begin
            o_free_PRegs[k] = entries[head];
            if (i_alloc_req[k]) begin
                o_free_PRegs[k] = entries[ptr_add(head, int'(n_alloc))];
                n_alloc         = n_alloc + fl_cnt'(1);
            end
        end
    end

    assign o_alloc_ok = (count >= n_alloc);

    always_comb begin
        for (int k = 0; k < FL_WIDTH; k++)
            pop_en[k] = i_alloc_req[k] && o_alloc_ok;
    end

`ifdef FREE_LIST_CHECK_EN
    preg_alloc_tracker u_tracker (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .pop_en       (pop_en),
        .pop_preg     (o_free_PRegs),
        .release_en   (i_release_en),
        .release_preg (i_release_preg),
        .count        (count),
        .push_en      (push_en),
        .err          (o_err)
    );
`else
    always_comb begin
        for (int k = 0; k < FL_WIDTH; k++)
            push_en[k] = i_release_en[k];
    end

    assign o_err = 1'b0;
`endif

    always_comb begin
        n_push = '0;
        for (int k = 0; k < FL_WIDTH; k++) begin
            push_ptr[k] = tail;
            if (push_en[k]) begin
                push_ptr[k] = ptr_add(tail, int'(n_push));
                n_push      = n_push + fl_cnt'(1);
            end
        end
    end

    // NOTE: the storage is deliberately reset: the reset image (entry j holds
    // P(NUM_AREGS+j)) is architectural state, not just a convenience.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= fl_cnt'(FL_DEPTH);
            for (int j = 0; j < FL_DEPTH; j++)
                entries[j] <= p_reg'(NUM_AREGS + j);
        end else begin
            for (int k = 0; k < FL_WIDTH; k++)
                if (push_en[k]) entries[push_ptr[k]] <= i_release_preg[k];
            if (o_alloc_ok) head <= ptr_add(head, int'(n_alloc));
            tail  <= ptr_add(tail, int'(n_push));
            count <= count + n_push - (o_alloc_ok ? n_alloc : '0);
        end
    end

    assign o_free_count = count;

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: queue-based free-list model checked every cycle,
// plus directed literal expectations; FREE_LIST_CHECK_EN selects the checked build.
module tb_preg_free_list;
    import Types::*;

`ifdef FREE_LIST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alloc_req    [0:FL_WIDTH-1];
    logic [PREG_W-1:0] free_pregs   [0:FL_WIDTH-1];
    logic              alloc_ok;
    logic              release_en   [0:FL_WIDTH-1];
    logic [PREG_W-1:0] release_preg [0:FL_WIDTH-1];
    logic [CNT_W-1:0]  free_count;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    preg_free_list dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_alloc_req    (alloc_req),
        .o_free_PRegs   (free_pregs),
        .o_alloc_ok     (alloc_ok),
        .i_release_en   (release_en),
        .i_release_preg (release_preg),
        .o_free_count   (free_count),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model: the free list is an ordered queue of preg numbers.
    int mq[$];
    int m_pre[$];
    bit merr;
    int m_n, m_acc;
    bit m_bad;

    function automatic bit in_pre(input int v);
        foreach (m_pre[i]) if (m_pre[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            for (int j = 0; j < FL_DEPTH; j++) mq.push_back(NUM_AREGS + j);
            merr = 1'b0;
        end else begin
            m_pre = mq;
            m_n = 0;
            for (int k = 0; k < FL_WIDTH; k++) if (alloc_req[k]) m_n++;
            if (m_pre.size() >= m_n)
                for (int k = 0; k < m_n; k++) void'(mq.pop_front());
            m_acc = 0;
            for (int k = 0; k < FL_WIDTH; k++) begin
                if (release_en[k]) begin
                    m_bad = 1'b0;
                    if (CHK) begin
                        m_bad = in_pre(int'(release_preg[k])) || (m_pre.size() + m_acc >= FL_DEPTH);
                        for (int j = 0; j < k; j++)
                            if (release_en[j] && release_preg[j] == release_preg[k]) m_bad = 1'b1;
                    end
                    if (m_bad) merr = 1'b1;
                    else begin
                        mq.push_back(int'(release_preg[k]));
                        m_acc++;
                    end
                end
            end
        end
    end

    int  c_n, c_r;
    bit  c_ok;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            c_n = 0;
            for (int k = 0; k < FL_WIDTH; k++) if (alloc_req[k]) c_n++;
            c_ok = (mq.size() >= c_n);
            check("model_alloc_ok", alloc_ok, c_ok);
            if (c_ok) begin
                c_r = 0;
                for (int k = 0; k < FL_WIDTH; k++) begin
                    if (alloc_req[k]) begin
                        check($sformatf("model_grant%0d", k), free_pregs[k], mq[c_r]);
                        c_r++;
                    end
                end
            end
            check("model_free_count", free_count, mq.size());
            check("model_err", err, merr);
        end
    end

    task automatic drive(input logic r0, input logic r1, input logic e0, input logic e1,
                         input int p0, input int p1);
        alloc_req[0]    = r0;
        alloc_req[1]    = r1;
        release_en[0]   = e0;
        release_en[1]   = e1;
        release_preg[0] = PREG_W'(p0);
        release_preg[1] = PREG_W'(p1);
    endtask

    // Apply inputs just after a posedge; return at the following negedge.
    task automatic go(input logic r0, input logic r1, input logic e0, input logic e1,
                      input int p0, input int p1);
        @(posedge clk);
        #1;
        drive(r0, r1, e0, e1, p0, p1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int held[$];
    int prev0, prev1;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        do_reset();

        // Reset image
        go(0, 0, 0, 0, 0, 0);
        check("rst_count", free_count, 32);
        check("rst_ok", alloc_ok, 1);
        check("rst_grant0", free_pregs[0], 32);
        check("rst_grant1", free_pregs[1], 32);
        check("rst_err", err, 0);

        // Dual request from reset
        go(1, 1, 0, 0, 0, 0);
        check("dual_ok", alloc_ok, 1);
        check("dual_grant0", free_pregs[0], 32);
        check("dual_grant1", free_pregs[1], 33);
        go(0, 0, 0, 0, 0, 0);
        check("dual_count", free_count, 30);

        // Only slot 1 requests
        do_reset();
        go(0, 1, 0, 0, 0, 0);
        check("slot1_ok", alloc_ok, 1);
        check("slot1_grant", free_pregs[1], 32);
        go(0, 0, 0, 0, 0, 0);
        check("slot1_count", free_count, 31);

        // Drain to one entry, then all-or-nothing refusal
        for (int i = 0; i < 15; i++) go(1, 1, 0, 0, 0, 0);
        go(1, 1, 0, 0, 0, 0);
        check("short_count", free_count, 1);
        check("short_ok", alloc_ok, 0);
        go(1, 0, 0, 0, 0, 0);
        check("last_count", free_count, 1);
        check("last_ok", alloc_ok, 1);
        check("last_grant", free_pregs[0], 63);

        // Empty: release does not bypass into the same cycle's grant
        go(1, 1, 1, 1, 5, 7);
        check("empty_count", free_count, 0);
        check("empty_ok", alloc_ok, 0);
        go(1, 1, 0, 0, 0, 0);
        check("reuse_count", free_count, 2);
        check("reuse_ok", alloc_ok, 1);
        check("reuse_grant0", free_pregs[0], 5);
        check("reuse_grant1", free_pregs[1], 7);

        // Steady release/allocate so both pointers wrap; grants follow release order
        for (int p = 32; p < 64; p++) held.push_back(p);
        held.push_back(5);
        held.push_back(7);
        prev0 = 0;
        prev1 = 0;
        for (int i = 0; i <= 20; i++) begin
            int p0, p1;
            p0 = 0;
            p1 = 0;
            if (i < 20) begin
                p0 = held.pop_front();
                p1 = held.pop_front();
            end
            go(i > 0, i > 0, i < 20, i < 20, p0, p1);
            if (i > 0) begin
                check("wrap_ok", alloc_ok, 1);
                check("wrap_grant0", free_pregs[0], prev0);
                check("wrap_grant1", free_pregs[1], prev1);
                held.push_back(prev0);
                held.push_back(prev1);
            end
            check("wrap_count_bound", free_count <= FL_DEPTH, 1);
            prev0 = p0;
            prev1 = p1;
        end
        go(0, 0, 0, 0, 0, 0);
        check("wrap_end_count", free_count, 0);

        // Double release of P40, then asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 4; i++) go(1, 1, 0, 0, 0, 0);
        go(1, 0, 0, 0, 0, 0);
        go(0, 0, 1, 0, 40, 0);
        check("p40_pre_count", free_count, 23);
        go(0, 0, 1, 0, 40, 0);
        check("p40_once_count", free_count, 24);
        check("p40_once_err", err, 0);
        go(0, 0, 0, 0, 0, 0);
        check("p40_twice_count", free_count, CHK ? 24 : 25);
        check("p40_twice_err", err, CHK ? 1 : 0);
        go(0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0);
        check("p40_sticky_err", err, CHK ? 1 : 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_count", free_count, 32);
        check("async_rst_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        go(0, 0, 0, 0, 0, 0);
        check("post_rst_count", free_count, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
